// File: rtl/memoria_pkg.sv
// rtl/memoria_pkg.sv - shared defaults, FSM state type and ROM content rule for memoria_sequencial
package memoria_pkg;

    localparam int DATA_W_DEF  = 4;
    localparam int DEPTH_DEF   = 16;
    localparam int N_BANKS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        FIM
    } state_t;

    // Each bank is the one-hot walking pattern rotated by the bank number.
    function automatic logic [31:0] rom_word(input int addr, input int bank, input int data_w);
        return 32'd1 << ((addr + bank) % data_w);
    endfunction

endpackage

// File: rtl/rom_bancos.sv
// rtl/rom_bancos.sv - banked one-hot pattern ROM with registered, enable-gated read
module rom_bancos
    import memoria_pkg::*;
#(
    parameter  int DATA_W  = DATA_W_DEF,
    parameter  int DEPTH   = DEPTH_DEF,
    parameter  int N_BANKS = N_BANKS_DEF,
    localparam int ADDR_W  = $clog2(DEPTH),
    localparam int BANK_W  = $clog2(N_BANKS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [BANK_W-1:0] bank,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] mem [N_BANKS*DEPTH];
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    for (genvar i = 0; i < N_BANKS * DEPTH; i++) begin : g_rom
        assign mem[i] = DATA_W'(rom_word(i % DEPTH, i / DEPTH, DATA_W));
    end

    // The output register only loads on a read, so it holds its word while the consumer waits.
    always_comb begin
        data_d = data_q;
        if (rd_en) begin
            data_d = mem[{bank, addr}];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule

// File: rtl/memoria_sequencial.sv
// rtl/memoria_sequencial.sv - plays a selectable ROM bank word by word with next handshake and optional looping
module memoria_sequencial
    import memoria_pkg::*;
#(
    parameter  int DATA_W  = DATA_W_DEF,
    parameter  int DEPTH   = DEPTH_DEF,
    parameter  int N_BANKS = N_BANKS_DEF,
    localparam int ADDR_W  = $clog2(DEPTH),
    localparam int BANK_W  = $clog2(N_BANKS),
    localparam int LEN_W   = ADDR_W + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [BANK_W-1:0] bank,
    input  logic [LEN_W-1:0]  seq_len,
    input  logic              loop,
    input  logic              start,
    input  logic              next,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic [ADDR_W-1:0] address,
    output logic              busy,
    output logic              done
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              loop_q, loop_d;
    logic              last_word;

    assign last_word = ({1'b0, address_q} == (len_q - LEN_W'(1)));

    always_comb begin
        state_d   = state_q;
        address_d = address_q;
        bank_d    = bank_q;
        len_d     = len_q;
        loop_d    = loop_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bank_d    = bank;
                    len_d     = (seq_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : seq_len;
                    loop_d    = loop;
                    address_d = '0;
                    state_d   = (seq_len == '0) ? FIM : FETCH;
                end
            end
            FETCH: state_d = HOLD;
            HOLD: begin
                if (next) begin
                    state_d = FETCH;
                    if (!last_word) begin
                        address_d = address_q + ADDR_W'(1);
                    end else if (loop_q) begin
                        address_d = '0;
                    end else begin
                        state_d = FIM;
                    end
                end
            end
            FIM:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            address_q <= '0;
            bank_q    <= '0;
            len_q     <= '0;
            loop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            address_q <= address_d;
            bank_q    <= bank_d;
            len_q     <= len_d;
            loop_q    <= loop_d;
        end
    end

    rom_bancos #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .N_BANKS(N_BANKS)
    ) u_rom (
        .clock(clock),
        .reset(reset),
        .rd_en(state_q == FETCH),
        .bank (bank_q),
        .addr (address_q),
        .data (data_out)
    );

    assign data_valid = (state_q == HOLD);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == FIM);
    assign address    = address_q;

endmodule

// File: tb/tb_memoria_sequencial.sv
// tb/tb_memoria_sequencial.sv - scoreboard bench for memoria_sequencial with random handshake noise
module tb_memoria_sequencial;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 16;

    typedef struct {
        bit       is_done;
        bit [3:0] data;
        bit [3:0] addr;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] bank = '0;
    logic [4:0] seq_len = '0;
    logic       loop = 1'b0;
    logic       start = 1'b0;
    logic       next = 1'b0;
    logic [3:0] data_out;
    logic       data_valid;
    logic [3:0] address;
    logic       busy;
    logic       done;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    memoria_sequencial dut (
        .clock     (clock),
        .reset     (reset),
        .bank      (bank),
        .seq_len   (seq_len),
        .loop      (loop),
        .start     (start),
        .next      (next),
        .data_out  (data_out),
        .data_valid(data_valid),
        .address   (address),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_data_out"}, int'(data_out), 0);
        chk({name, "_data_valid"}, int'(data_valid), 0);
        chk({name, "_address"}, int'(address), 0);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_done"}, int'(done), 0);
    endtask

    // Monitor: each rising data_valid is a fresh word; each done is an end-of-sequence event.
    bit       prev_valid = 1'b0;
    bit       prev_done  = 1'b0;
    bit [3:0] held       = '0;
    exp_t     e;

    always @(negedge clock) begin
        if (!reset) begin
            if (data_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("word_kind", 0, int'(e.is_done));
                    chk("data_out", int'(data_out), int'(e.data));
                    chk("address", int'(address), int'(e.addr));
                end
                held = data_out;
            end else if (data_valid) begin
                chk("hold_stable", int'(data_out), int'(held));
            end
            if (done) begin
                chk("done_single_cycle", int'(prev_done), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_kind", 1, int'(e.is_done));
                end
            end
            if (prev_done) begin
                chk("busy_after_done", int'(busy), 0);
            end
            prev_valid = data_valid;
            prev_done  = done;
        end else begin
            prev_valid = 1'b0;
            prev_done  = 1'b0;
        end
    end

    task automatic run_seq(input int b, input int len, input bit lp, input int n_loop);
        int   eff;
        bit   lp_eff;
        int   nwords;
        int   consumed;
        bit   fin;
        int   a;
        exp_t x;
        eff      = (len > DEPTH) ? DEPTH : len;
        lp_eff   = lp && (eff > 0);
        nwords   = lp_eff ? n_loop : eff;
        consumed = 0;
        fin      = 1'b0;
        for (int k = 0; k < nwords + (lp_eff ? 1 : 0); k++) begin
            a         = k % eff;
            x.is_done = 1'b0;
            x.addr    = 4'(a);
            x.data    = 4'(1 << ((a + b) % DATA_W));
            exp_q.push_back(x);
        end
        if (!lp_eff) begin
            x.is_done = 1'b1;
            x.addr    = '0;
            x.data    = '0;
            exp_q.push_back(x);
        end
        @(negedge clock);
        start   = 1'b1;
        bank    = 2'(b);
        seq_len = 5'(len);
        loop    = lp;
        next    = 1'($urandom);
        for (int cyc = 1; cyc <= 600 && !fin; cyc++) begin
            @(negedge clock);
            start   = ($urandom % 4) == 0;
            bank    = 2'($urandom);
            seq_len = 5'($urandom);
            loop    = 1'($urandom);
            if (cyc == 2 && eff > 0) chk("start_to_valid", int'(data_valid), 1);
            if (cyc == 1 && eff == 0) chk("len0_done_latency", int'(done), 1);
            if (!lp_eff && consumed == nwords) begin
                next = 1'b0;
                if (!busy) begin
                    start = 1'b0;
                    fin   = 1'b1;
                end
            end else if (lp_eff && consumed == nwords) begin
                next = 1'b0;
                if (data_valid) begin
                    start = 1'b0;
                    #2 reset = 1'b1;
                    #1 chk_outputs_zero("reset_in_hold");
                    #1 reset = 1'b0;
                    fin = 1'b1;
                end
            end else if (data_valid) begin
                next = 1'($urandom);
                if (next) consumed++;
            end else begin
                next = 1'($urandom);
            end
        end
        if (!fin) chk("sequence_timeout", 1, 0);
        start = 1'b0;
        next  = 1'b0;
        chk("scoreboard_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk_outputs_zero("reset_state");
        reset = 1'b0;
        run_seq(0, 4, 1'b0, 0);
        run_seq(1, 2, 1'b0, 0);
        run_seq(0, 3, 1'b1, 6);
        run_seq(2, 0, 1'b0, 0);
        run_seq(3, 20, 1'b0, 0);
        run_seq(0, 8, 1'b1, 5);
        run_seq(2, 16, 1'b1, 20);
        run_seq(1, 1, 1'b1, 3);
        for (int i = 0; i < 12; i++) begin
            run_seq(int'($urandom_range(0, 3)), int'($urandom_range(0, 31)),
                    1'($urandom), int'($urandom_range(1, 20)));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
